// File: rtl/aes_axis_block_packer.sv
// AXI-Stream front-end for the AES controller: captures a command word per
// frame, packs payload words MSW-first into blocks and queues them in a
// first-word-fall-through FIFO. A tlast inside a block flushes it zero-padded.
module aes_axis_block_packer #(
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned BLK_WORDS       = 4,
  parameter int unsigned CMD_WIDTH       = 32,
  parameter int unsigned FIFO_DEPTH      = 16,
  parameter int unsigned FIFO_ADDR_WIDTH = 4,
  parameter int unsigned CNT_WIDTH       = 16
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              s_axis_tvalid,
  output logic                              s_axis_tready,
  input  logic [DATA_WIDTH-1:0]             s_axis_tdata,
  input  logic                              s_axis_tlast,
  output logic [CMD_WIDTH-1:0]              cmd,
  output logic                              cmd_valid,
  input  logic                              cmd_ack,
  input  logic                              blk_rd_e,
  output logic [DATA_WIDTH*BLK_WORDS-1:0]   blk_rdata,
  output logic                              blk_rlast,
  output logic                              blk_empty,
  output logic                              blk_full,
  output logic                              blk_almost_full,
  output logic                              frame_done,
  input  logic                              frame_release,
  output logic [CNT_WIDTH-1:0]              frame_blocks,
  output logic [$clog2(BLK_WORDS):0]        frame_pad_words
);

  localparam int unsigned BLK_WIDTH = DATA_WIDTH * BLK_WORDS;
  localparam int unsigned WCNT_W    = $clog2(BLK_WORDS);
  localparam int unsigned PAD_W     = WCNT_W + 1;
  localparam int unsigned OCC_W     = FIFO_ADDR_WIDTH + 1;

  typedef enum logic [1:0] {
    ST_GET_CMD = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_HOLD    = 2'd2
  } state_e;

  state_e                     state_q, state_d;
  logic [WCNT_W-1:0]          word_cnt_q, word_cnt_d;
  logic [BLK_WIDTH-1:0]       shift_q, shift_d;
  logic [CMD_WIDTH-1:0]       cmd_q, cmd_d;
  logic                       cmd_valid_q, cmd_valid_d;
  logic                       frame_done_q, frame_done_d;
  logic [CNT_WIDTH-1:0]       frame_blocks_q, frame_blocks_d;
  logic [PAD_W-1:0]           frame_pad_q, frame_pad_d;
  logic [FIFO_ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]           occ_q, occ_d;
  logic [BLK_WIDTH:0]         mem_q [FIFO_DEPTH];

  logic                       empty_c;
  logic                       full_c;
  logic                       tready_c;
  logic                       accept_c;
  logic                       rd_en_c;
  logic                       wr_en_c;
  logic                       wr_last_c;
  logic [BLK_WIDTH-1:0]       wr_data_c;
  logic [BLK_WIDTH-1:0]       blk_next_c;
  logic [PAD_W-1:0]           pad_c;
  logic [BLK_WIDTH:0]         head_c;

  // FIFO status decoded from the registered occupancy
  always_comb begin
    empty_c = (occ_q == '0);
    full_c  = (occ_q == OCC_W'(FIFO_DEPTH));
    head_c  = mem_q[rd_ptr_q];
  end

  // Upstream ready depends only on registered state
  always_comb begin
    tready_c = 1'b0;
    unique case (state_q)
      ST_GET_CMD: tready_c = !cmd_valid_q && !frame_done_q;
      ST_PAYLOAD: tready_c = !full_c;
      default:    tready_c = 1'b0;
    endcase
  end

  // Next-state, packing and FIFO pointer logic
  always_comb begin
    state_d        = state_q;
    word_cnt_d     = word_cnt_q;
    shift_d        = shift_q;
    cmd_d          = cmd_q;
    cmd_valid_d    = cmd_valid_q;
    frame_done_d   = frame_done_q;
    frame_blocks_d = frame_blocks_q;
    frame_pad_d    = frame_pad_q;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    occ_d          = occ_q;
    wr_en_c        = 1'b0;
    wr_last_c      = 1'b0;
    wr_data_c      = '0;

    accept_c   = s_axis_tvalid && tready_c;
    rd_en_c    = blk_rd_e && !empty_c;
    blk_next_c = {shift_q[BLK_WIDTH-DATA_WIDTH-1:0], s_axis_tdata};
    pad_c      = PAD_W'(BLK_WORDS - 1) - PAD_W'(word_cnt_q);

    if (cmd_valid_q && cmd_ack) begin
      cmd_valid_d = 1'b0;
    end

    unique case (state_q)
      ST_GET_CMD: begin
        if (accept_c) begin
          cmd_d          = s_axis_tdata[CMD_WIDTH-1:0];
          cmd_valid_d    = 1'b1;
          frame_blocks_d = '0;
          frame_pad_d    = '0;
          if (s_axis_tlast) begin
            frame_done_d = 1'b1;
            state_d      = ST_HOLD;
          end else begin
            state_d      = ST_PAYLOAD;
          end
        end
      end
      ST_PAYLOAD: begin
        if (accept_c) begin
          if (word_cnt_q == WCNT_W'(BLK_WORDS - 1)) begin
            wr_en_c    = 1'b1;
            wr_data_c  = blk_next_c;
            wr_last_c  = s_axis_tlast;
            word_cnt_d = '0;
            shift_d    = '0;
          end else if (s_axis_tlast) begin
            // Left-justify the partial block, zero filling the low words
            wr_en_c     = 1'b1;
            wr_data_c   = blk_next_c << (DATA_WIDTH * 32'(pad_c));
            wr_last_c   = 1'b1;
            frame_pad_d = pad_c;
            word_cnt_d  = '0;
            shift_d     = '0;
          end else begin
            shift_d    = blk_next_c;
            word_cnt_d = word_cnt_q + WCNT_W'(1);
          end
          if (wr_en_c && (frame_blocks_q != '1)) begin
            frame_blocks_d = frame_blocks_q + CNT_WIDTH'(1);
          end
          if (s_axis_tlast) begin
            frame_done_d = 1'b1;
            state_d      = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (frame_release) begin
          frame_done_d = 1'b0;
          state_d      = ST_GET_CMD;
        end
      end
      default: state_d = ST_GET_CMD;
    endcase

    if (wr_en_c) begin
      wr_ptr_d = wr_ptr_q + FIFO_ADDR_WIDTH'(1);
    end
    if (rd_en_c) begin
      rd_ptr_d = rd_ptr_q + FIFO_ADDR_WIDTH'(1);
    end
    unique case ({wr_en_c, rd_en_c})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase
  end

  // Control and status registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_GET_CMD;
      word_cnt_q     <= '0;
      shift_q        <= '0;
      cmd_q          <= '0;
      cmd_valid_q    <= 1'b0;
      frame_done_q   <= 1'b0;
      frame_blocks_q <= '0;
      frame_pad_q    <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      occ_q          <= '0;
    end else begin
      state_q        <= state_d;
      word_cnt_q     <= word_cnt_d;
      shift_q        <= shift_d;
      cmd_q          <= cmd_d;
      cmd_valid_q    <= cmd_valid_d;
      frame_done_q   <= frame_done_d;
      frame_blocks_q <= frame_blocks_d;
      frame_pad_q    <= frame_pad_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      occ_q          <= occ_d;
    end
  end

  // Block storage: {rlast, data} per entry, contents are don't-care when empty
  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      mem_q[wr_ptr_q] <= {wr_last_c, wr_data_c};
    end
  end

  assign s_axis_tready   = tready_c;
  assign cmd             = cmd_q;
  assign cmd_valid       = cmd_valid_q;
  assign frame_done      = frame_done_q;
  assign frame_blocks    = frame_blocks_q;
  assign frame_pad_words = frame_pad_q;
  assign blk_empty       = empty_c;
  assign blk_full        = full_c;
  assign blk_almost_full = (occ_q == OCC_W'(FIFO_DEPTH - 1));
  assign blk_rdata       = empty_c ? '0 : head_c[BLK_WIDTH-1:0];
  assign blk_rlast       = !empty_c && head_c[BLK_WIDTH];

endmodule

// File: tb/tb_aes_axis_block_packer.sv
// Bench for aes_axis_block_packer: a frame-level model (word lists and a block
// queue) is compared against the DUT every cycle, plus directed literal checks.
module tb_aes_axis_block_packer;

  localparam int unsigned DW    = 32;
  localparam int unsigned BWDS  = 4;
  localparam int unsigned BW    = DW * BWDS;
  localparam int unsigned DEPTH = 16;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           s_axis_tvalid = 1'b0;
  logic           s_axis_tready;
  logic [DW-1:0]  s_axis_tdata = '0;
  logic           s_axis_tlast = 1'b0;
  logic [31:0]    cmd;
  logic           cmd_valid;
  logic           cmd_ack = 1'b0;
  logic           blk_rd_e = 1'b0;
  logic [BW-1:0]  blk_rdata;
  logic           blk_rlast;
  logic           blk_empty;
  logic           blk_full;
  logic           blk_almost_full;
  logic           frame_done;
  logic           frame_release = 1'b0;
  logic [15:0]    frame_blocks;
  logic [2:0]     frame_pad_words;

  aes_axis_block_packer #(
    .DATA_WIDTH(32), .BLK_WORDS(4), .CMD_WIDTH(32),
    .FIFO_DEPTH(16), .FIFO_ADDR_WIDTH(4), .CNT_WIDTH(16)
  ) dut (
    .clk(clk), .reset(reset),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tdata(s_axis_tdata), .s_axis_tlast(s_axis_tlast),
    .cmd(cmd), .cmd_valid(cmd_valid), .cmd_ack(cmd_ack),
    .blk_rd_e(blk_rd_e), .blk_rdata(blk_rdata), .blk_rlast(blk_rlast),
    .blk_empty(blk_empty), .blk_full(blk_full), .blk_almost_full(blk_almost_full),
    .frame_done(frame_done), .frame_release(frame_release),
    .frame_blocks(frame_blocks), .frame_pad_words(frame_pad_words)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed { logic last; logic [BW-1:0] data; } blk_t;
  blk_t        m_fifo[$];
  logic [31:0] m_words[$];
  int          m_phase = 0;   // 0 waiting for command, 1 in payload, 2 frame closed
  logic [31:0] m_cmd = '0;
  bit          m_cmd_valid = 0;
  int          m_blocks = 0;
  int          m_pad = 0;
  bit          chk_en = 0;

  function automatic bit m_tready();
    if (m_phase == 0) return !m_cmd_valid;
    if (m_phase == 1) return m_fifo.size() < DEPTH;
    return 1'b0;
  endfunction

  initial forever begin
    bit   acc, pop;
    blk_t b;
    @(posedge clk);
    acc = s_axis_tvalid && m_tready();
    pop = blk_rd_e && (m_fifo.size() > 0);
    if (reset) begin
      m_fifo.delete(); m_words.delete();
      m_phase = 0; m_cmd = '0; m_cmd_valid = 0; m_blocks = 0; m_pad = 0;
    end else begin
      if (m_cmd_valid && cmd_ack) m_cmd_valid = 0;
      if (pop) void'(m_fifo.pop_front());
      if (acc && m_phase == 0) begin
        m_cmd = s_axis_tdata; m_cmd_valid = 1; m_blocks = 0; m_pad = 0;
        m_phase = s_axis_tlast ? 2 : 1;
      end else if (acc) begin
        m_words.push_back(s_axis_tdata);
        if (m_words.size() == BWDS || s_axis_tlast) begin
          b.data = '0;
          foreach (m_words[i]) b.data[(BWDS-1-i)*DW +: DW] = m_words[i];
          b.last = s_axis_tlast;
          if (m_words.size() < BWDS) m_pad = BWDS - m_words.size();
          m_fifo.push_back(b);
          m_words.delete();
          if (m_blocks < 65535) m_blocks++;
        end
        if (s_axis_tlast) m_phase = 2;
      end else if (m_phase == 2 && frame_release) begin
        m_phase = 0;
      end
    end
    chk_en = 1;
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("tready",       BW'(s_axis_tready),   BW'(m_tready()));
      chk("cmd_valid",    BW'(cmd_valid),       BW'(m_cmd_valid));
      chk("cmd",          BW'(cmd),             BW'(m_cmd));
      chk("frame_done",   BW'(frame_done),      BW'(m_phase == 2));
      chk("frame_blocks", BW'(frame_blocks),    BW'(m_blocks));
      chk("frame_pad",    BW'(frame_pad_words), BW'(m_pad));
      chk("blk_empty",    BW'(blk_empty),       BW'(m_fifo.size() == 0));
      chk("blk_full",     BW'(blk_full),        BW'(m_fifo.size() == DEPTH));
      chk("blk_afull",    BW'(blk_almost_full), BW'(m_fifo.size() == DEPTH-1));
      if (m_fifo.size() > 0) begin
        chk("blk_rdata", blk_rdata,      m_fifo[0].data);
        chk("blk_rlast", BW'(blk_rlast), BW'(m_fifo[0].last));
      end else begin
        chk("blk_rlast_empty", BW'(blk_rlast), BW'(0));
      end
    end
  end

  // ---------------- random consumer ----------------
  bit auto_en = 0;
  bit gaps    = 0;

  initial forever begin
    @(negedge clk);
    if (auto_en) begin
      blk_rd_e      = ($urandom_range(99) < 40);
      cmd_ack       = ($urandom_range(99) < 30);
      frame_release = ($urandom_range(99) < 30);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_word(input logic [31:0] d, input logic l);
    int guard = 0;
    if (gaps) repeat ($urandom_range(2)) @(negedge clk);
    s_axis_tdata = d; s_axis_tlast = l; s_axis_tvalid = 1'b1;
    while (!s_axis_tready && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    if (!s_axis_tready) begin
      n_checks++; n_fail++;
      $display("FAIL send_timeout: word %h never accepted at %0t", d, $time);
    end else begin
      @(negedge clk);
    end
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
  endtask

  task automatic send_frame(input logic [31:0] c, input int n, input logic [31:0] base, input bit rnd);
    send_word(c, n == 0);
    for (int i = 0; i < n; i++) send_word(rnd ? 32'($urandom) : base + 32'(i), i == n-1);
  endtask

  task automatic pop_one();
    blk_rd_e = 1'b1; @(negedge clk); blk_rd_e = 1'b0;
  endtask

  task automatic ack_one();
    cmd_ack = 1'b1; @(negedge clk); cmd_ack = 1'b0;
  endtask

  task automatic release_one();
    frame_release = 1'b1; @(negedge clk); frame_release = 1'b0;
  endtask

  task automatic drain();
    int g = 0;
    blk_rd_e = 1'b1;
    while (!blk_empty && g < 100) begin @(negedge clk); g++; end
    blk_rd_e = 1'b0;
    chk("drain_empty", BW'(blk_empty), BW'(1));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst_empty", BW'(blk_empty), BW'(1));
    chk("rst_tready", BW'(s_axis_tready), BW'(1));
    chk("rst_cmd_valid", BW'(cmd_valid), BW'(0));

    // 1: two full blocks
    send_frame(32'h20, 8, 32'h0, 0);
    chk("t1_done", BW'(frame_done), BW'(1));
    chk("t1_blocks", BW'(frame_blocks), BW'(2));
    chk("t1_pad", BW'(frame_pad_words), BW'(0));
    chk("t1_blk0", blk_rdata, 128'h00000000_00000001_00000002_00000003);
    chk("t1_rlast0", BW'(blk_rlast), BW'(0));
    pop_one();
    chk("t1_blk1", blk_rdata, 128'h00000004_00000005_00000006_00000007);
    chk("t1_rlast1", BW'(blk_rlast), BW'(1));
    pop_one(); ack_one(); release_one();

    // 2: mid-block tlast
    send_frame(32'h22, 5, 32'hA1, 0);
    chk("t2_blocks", BW'(frame_blocks), BW'(2));
    chk("t2_pad", BW'(frame_pad_words), BW'(3));
    chk("t2_blk0", blk_rdata, 128'h000000A1_000000A2_000000A3_000000A4);
    pop_one();
    chk("t2_blk1", blk_rdata, 128'h000000A5_00000000_00000000_00000000);
    chk("t2_rlast1", BW'(blk_rlast), BW'(1));
    pop_one(); ack_one(); release_one();

    // 3: command-only frame
    send_frame(32'h11, 0, 32'h0, 0);
    chk("t3_cmd", BW'(cmd), BW'(32'h11));
    chk("t3_cmd_valid", BW'(cmd_valid), BW'(1));
    chk("t3_done", BW'(frame_done), BW'(1));
    chk("t3_empty", BW'(blk_empty), BW'(1));
    chk("t3_tready_hold", BW'(s_axis_tready), BW'(0));
    ack_one();
    chk("t3_tready_ack", BW'(s_axis_tready), BW'(0));
    release_one();
    chk("t3_tready_rel", BW'(s_axis_tready), BW'(1));

    // 4: fill FIFO, stall, one pop, 17th block, drain across wrap
    send_word(32'h44, 1'b0);
    for (int i = 0; i < 64; i++) send_word(32'h1000 + 32'(i), 1'b0);
    chk("t4_full", BW'(blk_full), BW'(1));
    s_axis_tdata = 32'h1040; s_axis_tlast = 1'b0; s_axis_tvalid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("t4_stall", BW'(s_axis_tready), BW'(0));
    end
    pop_one();
    chk("t4_tready_back", BW'(s_axis_tready), BW'(1));
    for (int i = 64; i < 68; i++) send_word(32'h1000 + 32'(i), i == 67);
    chk("t4_full2", BW'(blk_full), BW'(1));
    for (int i = 0; i < 16; i++) pop_one();
    chk("t4_empty", BW'(blk_empty), BW'(1));
    ack_one(); release_one();

    // 5: read and write together at occupancy 15, then cmd blocked by cmd_valid
    send_word(32'h55, 1'b0);
    for (int i = 0; i < 63; i++) send_word(32'h5000 + 32'(i), 1'b0);
    chk("t5_afull_pre", BW'(blk_almost_full), BW'(1));
    blk_rd_e = 1'b1;
    send_word(32'h503F, 1'b1);
    blk_rd_e = 1'b0;
    chk("t5_afull", BW'(blk_almost_full), BW'(1));
    chk("t5_notfull", BW'(blk_full), BW'(0));
    chk("t5_blocks", BW'(frame_blocks), BW'(16));
    release_one();
    s_axis_tdata = 32'h66; s_axis_tlast = 1'b0; s_axis_tvalid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("t5_cmd_blocked", BW'(s_axis_tready), BW'(0));
    end
    ack_one();
    chk("t5_cmd_unblocked", BW'(s_axis_tready), BW'(1));
    send_word(32'h66, 1'b0);
    chk("t5_cmd", BW'(cmd), BW'(32'h66));

    // 6: reset mid-block with 3 blocks queued
    drain();
    for (int i = 0; i < 14; i++) send_word(32'h6000 + 32'(i), 1'b0);
    reset = 1'b1; @(negedge clk); reset = 1'b0;
    chk("t6_empty", BW'(blk_empty), BW'(1));
    chk("t6_cmd_valid", BW'(cmd_valid), BW'(0));
    chk("t6_tready", BW'(s_axis_tready), BW'(1));
    chk("t6_blocks", BW'(frame_blocks), BW'(0));
    send_frame(32'h77, 4, 32'h7000, 0);
    chk("t6_blk", blk_rdata, 128'h00007000_00007001_00007002_00007003);
    chk("t6_rlast", BW'(blk_rlast), BW'(1));
    chk("t6_pad", BW'(frame_pad_words), BW'(0));
    pop_one(); ack_one(); release_one();

    // 7: randomized frames with random consumer
    gaps = 1; auto_en = 1;
    for (int f = 0; f < 40; f++) send_frame(32'($urandom), $urandom_range(0, 22), 32'h0, 1);
    repeat (200) @(negedge clk);
    auto_en = 0;
    blk_rd_e = 1'b0; cmd_ack = 1'b0; frame_release = 1'b0;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    n_fail++;
    $display("FAIL watchdog: run exceeded time limit at %0t", $time);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/aes_axis_block_packer.md
Name: aes_axis_block_packer

Overview:
Parametrised successor to the AES AXI-Stream slave front-end. Per frame it captures a leading command word, then packs payload words into BLK_WORDS-wide blocks, MSW first. Blocks go into an internal FIFO that the AES controller drains. Unlike the previous block, a tlast mid-block is handled: the partial block is flushed zero-padded and tagged last. Per-frame block count and pad count are reported, and the command is released through a valid/ack handshake.

Parameters:
DATA_WIDTH, 32, AXI-Stream tdata width in bits.
BLK_WORDS, 4, payload words per block (>=2); BLK_WIDTH = DATA_WIDTH*BLK_WORDS.
CMD_WIDTH, 32, captured command width (<= DATA_WIDTH, low bits of first word).
FIFO_DEPTH, 16, block FIFO entries.
FIFO_ADDR_WIDTH, 4, log2(FIFO_DEPTH).
CNT_WIDTH, 16, width of per-frame block counter.

Ports:
clk  in  1  single clock for all logic.
reset  in  1  synchronous, active-high reset.
s_axis_tvalid  in  1  upstream word valid.
s_axis_tready  out  1  upstream ready.
s_axis_tdata  in  DATA_WIDTH  upstream word.
s_axis_tlast  in  1  final word of frame.
cmd  out  CMD_WIDTH  captured command.
cmd_valid  out  1  cmd holds an unacknowledged command.
cmd_ack  in  1  consumer accepted cmd.
blk_rd_e  in  1  pop one block (ignored when empty).
blk_rdata  out  BLK_WIDTH  FIFO head block.
blk_rlast  out  1  head block is the frame's last.
blk_empty  out  1  FIFO empty.
blk_full  out  1  FIFO full.
blk_almost_full  out  1  FIFO holds FIFO_DEPTH-1 entries.
frame_done  out  1  level: frame fully accepted, awaiting release.
frame_release  in  1  downstream finished frame; re-arm.
frame_blocks  out  CNT_WIDTH  blocks written for the current/last frame.
frame_pad_words  out  log2(BLK_WORDS)+1  zero words padded into the last block.

Behaviour:
- Reset (reset=1 at posedge): state=GET_CMD; word_cnt=0; shift register=0; cmd=0; cmd_valid=0; frame_done=0; frame_blocks=0; frame_pad_words=0; FIFO emptied (blk_empty=1, blk_full=0, blk_almost_full=0, blk_rlast=0). Reset mid-frame discards the partial block and all FIFO content.
- Handshake: a word is accepted when tvalid && tready. tready is combinational from registered state only; it never depends on tvalid.
- GET_CMD: tready = !cmd_valid && !frame_done. On accept: cmd <= tdata[CMD_WIDTH-1:0], cmd_valid <= 1, frame_blocks <= 0, frame_pad_words <= 0.
  - tlast=0: go to PAYLOAD.
  - tlast=1 (command-only frame): frame_done <= 1, go to HOLD; no block written.
- cmd_valid clears on the cycle cmd_ack=1. cmd_ack with cmd_valid=0 is ignored.
- PAYLOAD: tready = !blk_full. On accept: blk_next = {shift[BLK_WIDTH-DATA_WIDTH-1:0], tdata}.
  - If word_cnt==BLK_WORDS-1: write blk_next to FIFO in the same cycle, rlast=tlast, word_cnt <= 0, frame_blocks++.
  - Else if tlast: write blk_next << (DATA_WIDTH*(BLK_WORDS-1-word_cnt)) (left-justified, zero fill), rlast=1, frame_pad_words <= BLK_WORDS-1-word_cnt, frame_blocks++, word_cnt <= 0.
  - Else: shift <= blk_next, word_cnt++.
  - When tlast is accepted: frame_done <= 1, go to HOLD.
- HOLD: tready=0. On frame_release: frame_done <= 0, go to GET_CMD. frame_release outside HOLD is ignored. frame_blocks and frame_pad_words hold until the next command word is accepted.
- Latency: a written block is visible at blk_rdata (blk_empty=0) on the cycle after the write.
- FIFO uses first-word-fall-through: blk_rdata and blk_rlast show the head entry; blk_rd_e advances it next cycle.
- Simultaneous read and write:
  - Allowed at any occupancy except full-with-write, which cannot occur because tready=0 when full.
  - Read and write in the same cycle leaves occupancy unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- frame_blocks saturates at all-ones; it never wraps.

Test Plan:
1. Frame cmd=0x0000_0020, payload 0x0..0x7 (8 words, tlast on 0x7), BLK_WORDS=4 -> two blocks 0x00000000_00000001_00000002_00000003 (rlast=0) and 0x...4_5_6_7 (rlast=1); frame_blocks=2, pad=0, frame_done=1.
2. Cmd plus 5 words 0xA1..0xA5 -> block 2 = 0x000000A5_00000000_00000000_00000000, rlast=1, frame_pad_words=3, frame_blocks=2.
3. Command-only frame (tlast on cmd word 0x11) -> cmd=0x11, cmd_valid=1, no FIFO write, frame_done=1; tready stays 0 until frame_release, then returns to 1.
4. FIFO_DEPTH=16, 17 full blocks streamed, no reads -> tready drops after the 16th write, blk_full=1. One blk_rd_e -> tready reasserts and the 17th block is stored; 16 pops return data in order across the pointer wrap.
5. blk_rd_e on the same cycle as the 4th word accept, occupancy 15 -> occupancy stays 15, data intact. Next frame's cmd is blocked while cmd_valid=1 with no cmd_ack, and accepted the cycle after cmd_ack.
6. reset asserted after word 2 of a block with 3 entries queued -> next cycle blk_empty=1, cmd_valid=0, state=GET_CMD; a fresh frame packs from word_cnt=0.
